// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter sharing one unified memory between fetch, load/store and loader.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mips_mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          halt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  owner_t        r_rdOwner;
  logic [DW-1:0] r_ifRdata;
  logic [DW-1:0] r_dmRdata;

  logic w_ef;
  logic w_promote;
  logic w_ldGnt;
  logic w_dmGnt;
  logic w_ifGnt;

  assign w_ef = if_req & ~halt;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] r_starveCnt;

  // Counts consecutive cycles an unmasked fetch waits; at the limit fetch jumps ahead of dm once.
  assign w_promote = (r_starveCnt == 3'(STARVE_LIMIT));

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_starveCnt <= 3'd0;
    end else if (w_ifGnt || !w_ef) begin
      r_starveCnt <= 3'd0;
    end else if (r_starveCnt != 3'd7) begin
      r_starveCnt <= r_starveCnt + 3'd1;
    end
  end
`else
  assign w_promote = 1'b0;
`endif

  // Fixed priority ld > dm > if; grants are forced low while reset is held.
  assign w_ldGnt = ~rst & ld_req;
  assign w_ifGnt = ~rst & ~ld_req & w_ef & (~dm_req | w_promote);
  assign w_dmGnt = ~rst & ~ld_req & dm_req & ~w_ifGnt;

  assign ld_gnt = w_ldGnt;
  assign dm_gnt = w_dmGnt;
  assign if_gnt = w_ifGnt;

  assign mem_en = w_ldGnt | w_dmGnt | w_ifGnt;
  assign mem_we = w_ldGnt | (w_dmGnt & dm_we);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_ldGnt) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (w_dmGnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (w_ifGnt) begin
      mem_addr  = if_addr;
    end
  end

  // Remembers who issued this cycle's read so next cycle's memory data is routed back to them.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_rdOwner <= OWN_NONE;
    end else if (w_ifGnt) begin
      r_rdOwner <= OWN_IF;
    end else if (w_dmGnt && !dm_we) begin
      r_rdOwner <= OWN_DM;
    end else begin
      r_rdOwner <= OWN_NONE;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_ifRdata <= '0;
      r_dmRdata <= '0;
    end else begin
      if (r_rdOwner == OWN_IF) begin
        r_ifRdata <= mem_rdata;
      end
      if (r_rdOwner == OWN_DM) begin
        r_dmRdata <= mem_rdata;
      end
    end
  end

  // Read data is presented alongside rvalid and then held until the next read for that port.
  assign if_rvalid = (r_rdOwner == OWN_IF);
  assign dm_rvalid = (r_rdOwner == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : r_ifRdata;
  assign dm_rdata  = dm_rvalid ? mem_rdata : r_dmRdata;

endmodule
